// File: rtl/irrigation_pkg.sv
// Shared types and level-probe helpers for the irrigation scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WATER  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  typedef enum logic {
    DRIPPER   = 1'b0,
    SPRINKLER = 1'b1
  } mode_t;

  // A probe reporting water while the probe below it is dry is physically
  // impossible, so it marks a broken or stuck probe.
  function automatic logic level_conflict(input logic low, input logic mid, input logic high);
    return (mid & ~low) | (high & ~mid);
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser plus tick-based stability filter for one sensor bit.
// Latency: 2 clocks of synchronisation + DEBOUNCE_TICKS ticks of stable input.
// Backpressure: none; the output simply follows the filtered input.
// Ports: clock, reset_n (async active-low), tick (time-base enable),
//        sample (raw asynchronous input), stable (debounced level, 0 at reset).
module sensor_debouncer #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic sample,
  output logic stable
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_a <= sample;
      sync_b <= sync_a;
      // Any tick on which the input agrees with the output restarts the count,
      // so only an unbroken run of differing ticks can flip the output.
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
          stable <= sync_b;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler with tank refill hysteresis and alarm.
// Latency: debounced request -> GRANT next edge -> valves one edge later; all outputs registered.
// Backpressure: none; requests are levels, non-granted zones simply wait their turn.
// Ports: clock, reset_n, tick; tank probes low/mid/high_water_level; earth_dry[ZONES];
//        air_humidity, low_temperature, alarm_clear -> water_supply_valvule, splinker_bomb,
//        dripper_valvule, zone_valve (one-hot), active_zone, busy, alarm, conflict_error.
module irrigation_zone_scheduler
  import irrigation_pkg::*;
#(
  parameter int ZONES          = 4,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int WATER_TICKS    = 600,
  parameter int SETTLE_TICKS   = 30
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     low_water_level,
  input  logic                     mid_water_level,
  input  logic                     high_water_level,
  input  logic [ZONES-1:0]         earth_dry,
  input  logic                     air_humidity,
  input  logic                     low_temperature,
  input  logic                     alarm_clear,
  output logic                     water_supply_valvule,
  output logic                     splinker_bomb,
  output logic                     dripper_valvule,
  output logic [ZONES-1:0]         zone_valve,
  output logic [$clog2(ZONES)-1:0] active_zone,
  output logic                     busy,
  output logic                     alarm,
  output logic                     conflict_error
);

  localparam int ZW   = $clog2(ZONES);
  localparam int NS   = ZONES + 5;
  localparam int TMAX = (WATER_TICKS > SETTLE_TICKS) ? WATER_TICKS : SETTLE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  logic [NS-1:0]    raw;
  logic [NS-1:0]    db;
  logic             lvl_low, lvl_mid, lvl_high, humid, cold;
  logic [ZONES-1:0] dry;
  logic             conflict, allowed, sprinkle_ok, sticky_next;
  logic [ZW-1:0]    grant_zone;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [ZW-1:0]    cur_zone;
  logic [ZW-1:0]    last_zone;
  logic             sticky;

  assign raw = {earth_dry, low_temperature, air_humidity,
                high_water_level, mid_water_level, low_water_level};

  for (genvar g = 0; g < NS; g++) begin : g_deb
    sensor_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick),
      .sample  (raw[g]),
      .stable  (db[g])
    );
  end

  assign lvl_low     = db[0];
  assign lvl_mid     = db[1];
  assign lvl_high    = db[2];
  assign humid       = db[3];
  assign cold        = db[4];
  assign dry         = db[NS-1:5];
  assign conflict    = level_conflict(lvl_low, lvl_mid, lvl_high);
  assign allowed     = lvl_low & ~conflict;
  assign sprinkle_ok = ~humid & ~cold & lvl_mid;
  // Set dominates clear so a clear pulse can never hide a live conflict.
  assign sticky_next = conflict | (sticky & ~alarm_clear);

  // First requesting zone strictly after the previous grant, wrapping around.
  function automatic logic [ZW-1:0] pick_zone(input logic [ZONES-1:0] req, input logic [ZW-1:0] last);
    logic [ZW-1:0] sel;
    logic [ZW-1:0] zidx;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= ZONES; i++) begin
      idx  = (int'(last) + i) % ZONES;
      zidx = ZW'(idx);
      if (!found && req[zidx]) begin
        sel   = zidx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign grant_zone = pick_zone(dry, last_zone);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      water_supply_valvule <= 1'b0;
      sticky               <= 1'b0;
      alarm                <= 1'b0;
      conflict_error       <= 1'b0;
    end else begin
      conflict_error <= conflict;
      sticky         <= sticky_next;
      alarm          <= sticky_next | ~lvl_low;
      // Hysteresis between mid and high probes; a broken probe set never refills.
      if (conflict || lvl_high) begin
        water_supply_valvule <= 1'b0;
      end else if (!lvl_mid) begin
        water_supply_valvule <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      timer           <= '0;
      cur_zone        <= '0;
      last_zone       <= ZW'(ZONES - 1);
      zone_valve      <= '0;
      splinker_bomb   <= 1'b0;
      dripper_valvule <= 1'b0;
      active_zone     <= '0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (allowed && (|dry)) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // Mode is decided once here and held for the whole grant.
          automatic mode_t m = sprinkle_ok ? SPRINKLER : DRIPPER;
          cur_zone        <= grant_zone;
          active_zone     <= grant_zone;
          timer           <= TW'(WATER_TICKS - 1);
          zone_valve      <= ZONES'(1) << grant_zone;
          splinker_bomb   <= (m == SPRINKLER);
          dripper_valvule <= (m == DRIPPER);
          state           <= WATER;
        end
        WATER: begin
          if (!allowed || !dry[cur_zone] || (tick && timer == '0)) begin
            state           <= SETTLE;
            timer           <= TW'(SETTLE_TICKS - 1);
            zone_valve      <= '0;
            splinker_bomb   <= 1'b0;
            dripper_valvule <= 1'b0;
            last_zone       <= cur_zone;
          end else if (tick) begin
            timer <= timer - 1'b1;
          end
        end
        SETTLE: begin
          if (tick) begin
            if (timer == '0) begin
              state       <= IDLE;
              busy        <= 1'b0;
              active_zone <= '0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
module tb_irrigation_zone_scheduler;

  localparam int ZONES = 4;
  localparam int DEB   = 2;
  localparam int WT    = 3;
  localparam int ST    = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             tick = 1'b1;
  logic             low_water_level = 1'b0;
  logic             mid_water_level = 1'b0;
  logic             high_water_level = 1'b0;
  logic [ZONES-1:0] earth_dry = '0;
  logic             air_humidity = 1'b0;
  logic             low_temperature = 1'b0;
  logic             alarm_clear = 1'b0;
  logic             water_supply_valvule;
  logic             splinker_bomb;
  logic             dripper_valvule;
  logic [ZONES-1:0] zone_valve;
  logic [1:0]       active_zone;
  logic             busy;
  logic             alarm;
  logic             conflict_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   zone;
    logic spr;
    int   dur;
  } grant_t;

  grant_t exp_q[$];

  always #5 clock = ~clock;

  irrigation_zone_scheduler #(
    .ZONES(ZONES), .DEBOUNCE_TICKS(DEB), .WATER_TICKS(WT), .SETTLE_TICKS(ST)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .tick                 (tick),
    .low_water_level      (low_water_level),
    .mid_water_level      (mid_water_level),
    .high_water_level     (high_water_level),
    .earth_dry            (earth_dry),
    .air_humidity         (air_humidity),
    .low_temperature      (low_temperature),
    .alarm_clear          (alarm_clear),
    .water_supply_valvule (water_supply_valvule),
    .splinker_bomb        (splinker_bomb),
    .dripper_valvule      (dripper_valvule),
    .zone_valve           (zone_valve),
    .active_zone          (active_zone),
    .busy                 (busy),
    .alarm                (alarm),
    .conflict_error       (conflict_error)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_levels(input logic h, input logic m, input logic l);
    high_water_level = h;
    mid_water_level  = m;
    low_water_level  = l;
  endtask

  // Waits for the next grant, pops its expectation and checks zone, mode,
  // watering length and settle length.
  task automatic observe_grant(input string name, input bit clear_dry);
    grant_t     e;
    logic [3:0] oh;
    int         waited, dur, settle;
    bit         mode_ok, settle_ok;
    waited = 0;
    while (zone_valve == '0 && waited < 60) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (zone_valve == '0) begin
      errors++;
      $display("FAIL %s_start: zone_valve=%b busy=%b, required a grant within 60 cycles", name, zone_valve, busy);
      return;
    end
    if (clear_dry) earth_dry = '0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: zone_valve=%b, required no grant", name, zone_valve);
      return;
    end
    e  = exp_q.pop_front();
    oh = 4'b0001 << e.zone;
    checks++;
    if (zone_valve !== oh) begin
      errors++;
      $display("FAIL %s_zone: zone_valve=%b required %b", name, zone_valve, oh);
    end
    checks++;
    if (active_zone !== 2'(e.zone)) begin
      errors++;
      $display("FAIL %s_active: active_zone=%0d required %0d", name, active_zone, e.zone);
    end
    mode_ok = 1'b1;
    dur     = 0;
    while (zone_valve != '0 && dur < 50) begin
      if (splinker_bomb !== e.spr || dripper_valvule !== ~e.spr || zone_valve !== oh) mode_ok = 1'b0;
      dur++;
      @(negedge clock);
    end
    checks++;
    if (!mode_ok) begin
      errors++;
      $display("FAIL %s_mode: pump/dripper changed during grant, required splinker=%b dripper=%b", name, e.spr, ~e.spr);
    end
    checks++;
    if (dur != e.dur) begin
      errors++;
      $display("FAIL %s_water_len: watered %0d cycles required %0d", name, dur, e.dur);
    end
    settle    = 0;
    settle_ok = 1'b1;
    while (busy && settle < 20) begin
      if (zone_valve != '0 || splinker_bomb || dripper_valvule) settle_ok = 1'b0;
      settle++;
      @(negedge clock);
    end
    checks++;
    if (settle != ST || !settle_ok) begin
      errors++;
      $display("FAIL %s_settle: settle %0d cycles (valves off=%b) required %0d with valves off", name, settle, settle_ok, ST);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(2);
    checks++;
    if ({water_supply_valvule, splinker_bomb, dripper_valvule, zone_valve} !== 7'b0) begin
      errors++;
      $display("FAIL reset_valves: got %b required 0", {water_supply_valvule, splinker_bomb, dripper_valvule, zone_valve});
    end
    checks++;
    if (active_zone !== 2'd0) begin
      errors++;
      $display("FAIL reset_active: active_zone=%0d required 0", active_zone);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
    checks++;
    if ({alarm, conflict_error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_alarm: alarm=%b conflict_error=%b required 0 0", alarm, conflict_error);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_sprinkler();
    air_humidity    = 1'b0;
    low_temperature = 1'b0;
    set_levels(1'b0, 1'b1, 1'b1);
    cycles(8);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL tank_ok_alarm: alarm=%b required 0", alarm);
    end
    exp_q.push_back('{zone: 0, spr: 1'b1, dur: WT});
    exp_q.push_back('{zone: 2, spr: 1'b1, dur: WT});
    earth_dry = 4'b0101;
    observe_grant("spr_z0", 1'b0);
    observe_grant("spr_z2", 1'b1);
    cycles(10);
    checks++;
    if (busy !== 1'b0 || zone_valve !== '0) begin
      errors++;
      $display("FAIL spr_no_regrant: busy=%b zone_valve=%b required 0 0", busy, zone_valve);
    end
  endtask

  task automatic test_dripper();
    low_temperature = 1'b1;
    cycles(8);
    exp_q.push_back('{zone: 1, spr: 1'b0, dur: WT});
    earth_dry = 4'b0010;
    // Timed so the debounced temperature turns warm while zone 1 is watering.
    cycles(3);
    low_temperature = 1'b0;
    observe_grant("drip_z1", 1'b1);
    cycles(6);
  endtask

  task automatic test_conflict();
    earth_dry = 4'b0001;
    set_levels(1'b1, 1'b0, 1'b1);
    cycles(8);
    checks++;
    if (conflict_error !== 1'b1 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL conflict_flags: conflict_error=%b alarm=%b required 1 1", conflict_error, alarm);
    end
    checks++;
    if (water_supply_valvule !== 1'b0) begin
      errors++;
      $display("FAIL conflict_refill: water_supply_valvule=%b required 0", water_supply_valvule);
    end
    checks++;
    if (busy !== 1'b0 || zone_valve !== '0) begin
      errors++;
      $display("FAIL conflict_no_grant: busy=%b zone_valve=%b required 0 0", busy, zone_valve);
    end
    alarm_clear = 1'b1;
    cycles(1);
    alarm_clear = 1'b0;
    cycles(2);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL clear_during_conflict: alarm=%b required 1", alarm);
    end
    earth_dry = '0;
    set_levels(1'b0, 1'b1, 1'b1);
    cycles(8);
    checks++;
    if (conflict_error !== 1'b0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_sticky: conflict_error=%b alarm=%b required 0 1", conflict_error, alarm);
    end
    alarm_clear = 1'b1;
    cycles(1);
    alarm_clear = 1'b0;
    cycles(2);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clear: alarm=%b required 0", alarm);
    end
  endtask

  task automatic test_abort();
    exp_q.push_back('{zone: 3, spr: 1'b1, dur: 2});
    earth_dry = 4'b1000;
    // Debounced tank drop lands on the second watering cycle.
    cycles(3);
    set_levels(1'b0, 1'b0, 1'b0);
    observe_grant("abort_z3", 1'b0);
    cycles(6);
    checks++;
    if (busy !== 1'b0 || zone_valve !== '0) begin
      errors++;
      $display("FAIL abort_hold: busy=%b zone_valve=%b required 0 0 while tank low", busy, zone_valve);
    end
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL abort_alarm: alarm=%b required 1 while tank low", alarm);
    end
    exp_q.push_back('{zone: 3, spr: 1'b1, dur: WT});
    set_levels(1'b0, 1'b1, 1'b1);
    observe_grant("regrant_z3", 1'b1);
    cycles(4);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL abort_alarm_release: alarm=%b required 0", alarm);
    end
  endtask

  task automatic test_tank_sweep();
    logic [2:0] lv [5];
    logic       want [5];
    lv   = '{3'b000, 3'b011, 3'b111, 3'b011, 3'b001};
    want = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    earth_dry = '0;
    for (int i = 0; i < 5; i++) begin
      set_levels(lv[i][2], lv[i][1], lv[i][0]);
      cycles(8);
      checks++;
      if (water_supply_valvule !== want[i]) begin
        errors++;
        $display("FAIL sweep_%0d: levels=%b water_supply_valvule=%b required %b", i, lv[i], water_supply_valvule, want[i]);
      end
    end
  endtask

  task automatic test_glitch();
    set_levels(1'b0, 1'b1, 1'b1);
    cycles(8);
    earth_dry[1] = 1'b1;
    cycles(1);
    earth_dry[1] = 1'b0;
    cycles(15);
    checks++;
    if (busy !== 1'b0 || zone_valve !== '0 || active_zone !== 2'd0) begin
      errors++;
      $display("FAIL glitch_ignored: busy=%b zone_valve=%b active_zone=%0d required 0", busy, zone_valve, active_zone);
    end
  endtask

  task automatic test_reset_mid_water();
    int waited;
    earth_dry = 4'b0001;
    waited = 0;
    while (zone_valve == '0 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (zone_valve !== 4'b0001 || splinker_bomb !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_water: zone_valve=%b splinker_bomb=%b required 0001 1", zone_valve, splinker_bomb);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({water_supply_valvule, splinker_bomb, dripper_valvule, zone_valve} !== 7'b0 ||
        busy !== 1'b0 || active_zone !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: valves=%b busy=%b active_zone=%0d required all 0",
               {water_supply_valvule, splinker_bomb, dripper_valvule, zone_valve}, busy, active_zone);
    end
    earth_dry = '0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_sprinkler();
    test_dripper();
    test_conflict();
    test_abort();
    test_tank_sweep();
    test_glitch();
    test_reset_mid_water();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants still expected, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Parametrised successor to the single-zone irrigation controller. It drives up to ZONES irrigation zones from one shared pump/valve set, with debounced sensors, tank-refill hysteresis, a latched alarm and timed round-robin watering. It sits between the raw sensor inputs and the valve/pump outputs. Its encoded status (active zone, mode, level) feeds the existing matrix and segment display path.

## Interface
Parameters:
- ZONES, 4, number of irrigation zones (2..8)
- DEBOUNCE_TICKS, 4, consecutive stable ticks before a debounced sensor changes (>=1)
- WATER_TICKS, 600, ticks one zone is watered per grant (>=1)
- SETTLE_TICKS, 30, ticks with all valves closed between grants (>=1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle enable pulse from clock_divisor; all time bases count ticks
- low_water_level, mid_water_level, high_water_level  in  1 each  tank level probes, 1 = water at probe
- earth_dry  in  ZONES  per-zone soil probe, 1 = zone needs water
- air_humidity  in  1  1 = humid air
- low_temperature  in  1  1 = cold
- alarm_clear  in  1  synchronous pulse that clears the sticky conflict alarm
- water_supply_valvule  out  1  tank refill valve
- splinker_bomb  out  1  sprinkler pump
- dripper_valvule  out  1  dripper valve
- zone_valve  out  ZONES  one-hot zone valve
- active_zone  out  $clog2(ZONES)  index of the granted zone; 0 when idle
- busy  out  1  high in GRANT/WATER/SETTLE
- alarm  out  1  sticky conflict, or tank below low probe
- conflict_error  out  1  live (unlatched) level-probe conflict

## Operation
- All inputs except tick and alarm_clear pass through a 2-flop synchroniser, then a debouncer. A debounced value follows its input only after the input has been stable for DEBOUNCE_TICKS consecutive ticks. Debounced values are 0 at reset.
- Conflict = (mid & !low) | (high & !mid), computed on debounced levels.
- Irrigation is allowed when low & !conflict.
- Refill valve: opens when !mid, closes when high, and holds its value otherwise. It is forced closed while conflict is present.
- Alarm: a sticky bit is set by conflict and cleared by alarm_clear only when conflict is 0. If set and clear coincide, set wins. alarm = sticky | !low.
- Mode is sprinkler when !air_humidity & !low_temperature & mid; otherwise dripper. Mode is latched in GRANT and held for the whole grant.
- FSM states:
  - IDLE: go to GRANT if allowed and any debounced earth_dry bit is set.
  - GRANT (1 cycle): choose the first requesting zone searching upward from last_zone+1, wrapping at ZONES-1. Latch the zone and mode, load the timer with WATER_TICKS-1, go to WATER.
  - WATER: the granted zone_valve bit and the pump or dripper are on. On each tick the timer decrements. Go to SETTLE on a tick with timer==0, or immediately (same cycle) when !allowed or the granted zone's earth_dry falls. Update last_zone on exit.
  - SETTLE: all valves off. Load SETTLE_TICKS-1 and go to IDLE on a tick with timer==0.
- last_zone resets to ZONES-1, so zone 0 is served first after reset.
- Requests from non-granted zones are ignored during WATER/SETTLE. They are not queued beyond their level.

## Timing
- All outputs are registered.
- Reset values: all valves/pumps 0, zone_valve 0, active_zone 0, busy 0, alarm 0, conflict_error 0; FSM in IDLE.
- Once a debounced request is visible in IDLE: GRANT on the next edge, valves asserted one edge later (2-cycle latency).
- Watering lasts exactly WATER_TICKS tick pulses; settle lasts exactly SETTLE_TICKS tick pulses.
- Abort: outputs drop 1 cycle after allowed falls.
- Timer width is $clog2(max(WATER_TICKS, SETTLE_TICKS)+1). Counters never wrap below 0.
- Reset mid-watering closes all outputs asynchronously.

## Structure
- Shared package irrigation_pkg holds the state enum (IDLE, GRANT, WATER, SETTLE), the mode enum (DRIPPER=0, SPRINKLER=1), and the conflict function.
- Sub-module: sensor_debouncer (synchroniser + tick-based stable counter, one per input bit, instantiated via generate).
- The round-robin picker is an in-module function.

## Test plan
All scenarios use ZONES=4, DEBOUNCE_TICKS=2, WATER_TICKS=3, SETTLE_TICKS=2, tick every cycle.
- low=mid=1, earth_dry=4'b0101, air dry, warm -> zone 0 sprinkler on 3 cycles, settle 2 cycles, then zone 2; active_zone 0 then 2.
- Same as above with low_temperature=1 -> dripper_valvule instead of splinker_bomb; mode unchanged when temperature toggles mid-grant.
- high=1, mid=0 -> conflict_error=1, alarm=1, refill closed, no grant. Clear the conflict, pulse alarm_clear -> alarm 0.
- Drop low during WATER -> valves 0 one cycle later, SETTLE, no regrant until low returns; alarm=1 while low=0.
- Tank sweep 000->011->111->011->001 -> refill valve 1,1,0,0,1 (hysteresis).
- One-cycle glitch on earth_dry[1] -> no grant; reset_n low during WATER -> all outputs 0 immediately.
